// File: rtl/pong_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_io_pkg
//  Desc     : Shared constants for the Pong BRAM I/O bridge: window layout,
//             word offsets, button bit positions and sequencer state codes.
//  Revision : 1.0  initial release
// ============================================================================
package pong_io_pkg;

    // Bus geometry
    localparam int          c_ADDR_W    = 16;
    localparam int          c_DATA_W    = 16;

    // I/O window layout
    localparam logic [15:0] c_IO_BASE   = 16'hFF00;
    localparam int          c_BTN_OFS   = 4;
    localparam int          c_NUM_RD    = 4;

    // Word offsets inside the I/O window (also the shadow indices)
    localparam int          c_BALL_X    = 0;
    localparam int          c_BALL_Y    = 1;
    localparam int          c_PAD_L     = 2;
    localparam int          c_PAD_R     = 3;
    localparam int          c_NUM_SHADOW = 4;

    // Button bit positions, buttons = {R_dn, R_up, L_dn, L_up}
    localparam int          c_BTN_L_UP  = 0;
    localparam int          c_BTN_L_DN  = 1;
    localparam int          c_BTN_R_UP  = 2;
    localparam int          c_BTN_R_DN  = 3;
    localparam int          c_BTN_W     = 4;

    // Sequencer state encoding
    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_WR     = 3'd1;
    localparam logic [2:0]  c_ST_RD     = 3'd2;
    localparam logic [2:0]  c_ST_DRAIN  = 3'd3;
    localparam logic [2:0]  c_ST_COMMIT = 3'd4;

endpackage : pong_io_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Desc     : Two-flop synchronizer for slow asynchronous level inputs.
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/bram_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : bram_io_bridge
//  Desc     : BRAM port-B master. Per frame: writes the button mailbox,
//             burst-reads the game-state words into staging and commits them
//             atomically to shadow registers for the renderer.
//  Revision : 1.0  initial release
// ============================================================================
module bram_io_bridge
    import pong_io_pkg::*;
#(
    parameter int                ADDR_W  = c_ADDR_W,
    parameter int                DATA_W  = c_DATA_W,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(c_IO_BASE),
    parameter int                BTN_OFS = c_BTN_OFS,
    // Must be at least c_NUM_SHADOW: words 0..3 feed the shadow outputs
    parameter int                NUM_RD  = c_NUM_RD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [c_BTN_W-1:0]   buttons,
    input  logic [DATA_W-1:0]    q_b,
    output logic [ADDR_W-1:0]    addr_b,
    output logic [DATA_W-1:0]    data_b,
    output logic                 we_b,
    output logic [DATA_W-1:0]    ball_x,
    output logic [DATA_W-1:0]    ball_y,
    output logic [DATA_W-1:0]    paddle_l,
    output logic [DATA_W-1:0]    paddle_r,
    output logic                 snapshot_valid,
    output logic                 busy
);

    localparam int                  c_IDX_W     = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(NUM_RD - 1);
    // Address sums wrap modulo 2^ADDR_W by construction
    localparam logic [ADDR_W-1:0]   c_MBOX_ADDR = IO_BASE + ADDR_W'(BTN_OFS);

    logic [c_BTN_W-1:0]  w_btn_sync;
    logic [DATA_W-1:0]   w_btn_word;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [DATA_W-1:0]   w_final [NUM_RD];

    logic [2:0]          r_state;
    logic                r_pending;
    logic                r_busy;
    logic                r_snap;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_q_vld;
    logic [c_IDX_W-1:0]  r_q_idx;
    logic [DATA_W-1:0]   r_stage  [NUM_RD];
    logic [DATA_W-1:0]   r_shadow [c_NUM_SHADOW];

    sync_2ff #(
        .WIDTH (c_BTN_W)
    ) u_btn_sync (
        .clk (clk),
        .rst (reset),
        .i_d (buttons),
        .o_q (w_btn_sync)
    );

    assign w_btn_word  = {{(DATA_W - c_BTN_W){1'b0}}, w_btn_sync};
    assign w_next_addr = IO_BASE + ADDR_W'(r_idx) + ADDR_W'(1);

    // The last word is still on q_b when DRAIN ends, so the commit takes it
    // straight from the BRAM output; all other words come from staging.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_final
            if (gi == NUM_RD - 1) begin : g_last
                assign w_final[gi] = q_b;
            end else begin : g_staged
                assign w_final[gi] = r_stage[gi];
            end
        end
    endgenerate

    // Read-data capture: q_b is valid the cycle after an RD address was on the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q_vld <= 1'b0;
            r_q_idx <= '0;
            for (int k = 0; k < NUM_RD; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_q_vld <= (r_state == c_ST_RD);
            r_q_idx <= r_idx;
            if (r_q_vld) begin
                r_stage[r_q_idx] <= q_b;
            end
        end
    end

    // Frame sequencer: IDLE -> WR -> RD x NUM_RD -> DRAIN -> COMMIT -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_snap    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= IO_BASE;
            r_data    <= '0;
            r_idx     <= '0;
            for (int k = 0; k < c_NUM_SHADOW; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            // One-deep request queue for frames that arrive while busy
            if (frame_start && (r_state != c_ST_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (frame_start || r_pending) begin
                        r_state   <= c_ST_WR;
                        r_busy    <= 1'b1;
                        r_pending <= 1'b0;
                        r_we      <= 1'b1;
                        r_addr    <= c_MBOX_ADDR;
                        r_data    <= w_btn_word;
                    end
                end
                c_ST_WR: begin
                    r_state <= c_ST_RD;
                    r_we    <= 1'b0;
                    r_addr  <= IO_BASE;
                    r_idx   <= '0;
                end
                c_ST_RD: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_idx  <= r_idx + c_IDX_W'(1);
                        r_addr <= w_next_addr;
                    end
                end
                c_ST_DRAIN: begin
                    r_state <= c_ST_COMMIT;
                    r_snap  <= 1'b1;
                    for (int k = 0; k < c_NUM_SHADOW; k++) begin
                        r_shadow[k] <= w_final[k];
                    end
                end
                c_ST_COMMIT: begin
                    r_state <= c_ST_IDLE;
                    r_snap  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_snap  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign addr_b         = r_addr;
    assign data_b         = r_data;
    assign we_b           = r_we;
    assign ball_x         = r_shadow[c_BALL_X];
    assign ball_y         = r_shadow[c_BALL_Y];
    assign paddle_l       = r_shadow[c_PAD_L];
    assign paddle_r       = r_shadow[c_PAD_R];
    assign snapshot_valid = r_snap;
    assign busy           = r_busy;

endmodule : bram_io_bridge
`default_nettype wire
